// File: rtl/mq_ring_buffer_if.sv
// Port bundle for mq_ring_buffer: packet write, flit read, DMA request and release.
interface mq_ring_buffer_if #(
  parameter int FLIT_W = 512,
  parameter int QID_W  = 9,
  parameter int AW     = 9
);
  logic              wr_en;
  logic              wr_sop;
  logic              wr_eop;
  logic [FLIT_W-1:0] wr_data;
  logic [QID_W-1:0]  wr_qid;
  logic [AW-1:0]     wr_size;
  logic              wr_ready;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic              rd_valid;
  logic [FLIT_W-1:0] rd_data;
  logic              dma_req_valid;
  logic              dma_req_ready;
  logic [AW-1:0]     dma_req_addr;
  logic [AW-1:0]     dma_req_size;
  logic [QID_W-1:0]  dma_req_qid;
  logic              rel_valid;
  logic [AW-1:0]     rel_addr;
  logic [AW:0]       occupancy;

  modport master (
    output wr_en, wr_sop, wr_eop, wr_data, wr_qid, wr_size,
    output rd_en, rd_addr, dma_req_ready, rel_valid, rel_addr,
    input  wr_ready, rd_valid, rd_data,
    input  dma_req_valid, dma_req_addr, dma_req_size, dma_req_qid, occupancy
  );

  modport slave (
    input  wr_en, wr_sop, wr_eop, wr_data, wr_qid, wr_size,
    input  rd_en, rd_addr, dma_req_ready, rel_valid, rel_addr,
    output wr_ready, rd_valid, rd_data,
    output dma_req_valid, dma_req_addr, dma_req_size, dma_req_qid, occupancy
  );
endinterface

// File: rtl/mq_ring_buffer.sv
// Packet ring buffer: contiguous flit storage with wrap padding, per-queue
// descriptor coalescing and a valid/ready DMA request port.
module mq_ring_buffer #(
  parameter int  DEPTH      = 512,
  parameter int  FLIT_W     = 512,
  parameter int  QID_W      = 9,
  parameter int  MAX_PKT    = 24,
  parameter int  DESC_DEPTH = 16,
  parameter int  MAX_MERGE  = 64,
  parameter int  MERGE_EN   = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             rst,
  mq_ring_buffer_if.slave bus
);
  localparam int CW = $clog2(DESC_DEPTH);

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [AW-1:0]    size;
    logic [QID_W-1:0] qid;
    logic             complete;
  } desc_t;

  logic [FLIT_W-1:0] mem [DEPTH];
  desc_t             desc_q [DESC_DEPTH];

  logic [AW-1:0]     head, tail, wr_ptr;
  logic              in_pkt;
  logic [CW-1:0]     dwr_idx, drd_idx, tail_idx;
  logic [CW:0]       count, count_nxt;
  logic              wr_ready_q;
  logic [AW:0]       occupancy_q;
  logic              rd_v1, rd_valid_q;
  logic [FLIT_W-1:0] rd_q, rd_data_q;

  logic              sop, cont, push, merge, pop, can_merge, dma_valid;
  logic [AW:0]       pkt_end, merge_sum, tail_end;
  logic [AW-1:0]     base, tail_nxt, head_nxt, occ_nxt, wr_addr;

  // NOTE: every signal written here is assigned on all paths (defaults first), so no latch is inferred.
  always_comb begin
    sop       = bus.wr_en & bus.wr_sop;
    cont      = bus.wr_en & ~bus.wr_sop & in_pkt;
    tail_idx  = dwr_idx - CW'(1);
    pkt_end   = {1'b0, tail} + {1'b0, bus.wr_size};
    base      = (pkt_end > (AW+1)'(DEPTH)) ? '0 : tail;
    merge_sum = {1'b0, desc_q[tail_idx].size} + {1'b0, bus.wr_size};
    tail_end  = {1'b0, desc_q[tail_idx].addr} + {1'b0, desc_q[tail_idx].size};
    // The tail entry is mergeable only when it is not also the head entry being issued.
    can_merge = (MERGE_EN != 0) && (count >= (CW+1)'(2))
             && (desc_q[tail_idx].qid == bus.wr_qid)
             && ({1'b0, base} == tail_end)
             && (merge_sum <= (AW+1)'(MAX_MERGE));
    merge     = sop & can_merge;
    push      = sop & ~can_merge;
    dma_valid = (count != '0) && desc_q[drd_idx].complete;
    pop       = dma_valid & bus.dma_req_ready;
    tail_nxt  = sop ? base + bus.wr_size : tail;
    head_nxt  = bus.rel_valid ? bus.rel_addr : head;
    occ_nxt   = tail_nxt - head_nxt;
    wr_addr   = sop ? base : wr_ptr;
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (CW+1)'(1);
    else if (!push && pop) count_nxt = count - (CW+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      wr_ptr      <= '0;
      in_pkt      <= 1'b0;
      count       <= '0;
      dwr_idx     <= '0;
      drd_idx     <= '0;
      wr_ready_q  <= 1'b0;
      occupancy_q <= '0;
      rd_v1       <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      head        <= head_nxt;
      tail        <= tail_nxt;
      count       <= count_nxt;
      // Room for worst-case padding plus a full packet, and one spare descriptor slot.
      wr_ready_q  <= ({1'b0, occ_nxt} <= (AW+1)'(DEPTH - 1 - 2 * MAX_PKT))
                  && (count_nxt <= (CW+1)'(DESC_DEPTH - 2));
      occupancy_q <= {1'b0, occ_nxt};
      if (push) dwr_idx <= dwr_idx + CW'(1);
      if (pop)  drd_idx <= drd_idx + CW'(1);
      if (sop) begin
        wr_ptr <= base + AW'(1);
        in_pkt <= ~bus.wr_eop;
      end else if (cont) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (bus.wr_eop) in_pkt <= 1'b0;
      end
      rd_v1      <= bus.rd_en;
      rd_valid_q <= rd_v1;
    end
  end

  // NOTE: flit and descriptor storage carry no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (sop | cont) mem[wr_addr] <= bus.wr_data;
    rd_q      <= mem[bus.rd_addr];
    rd_data_q <= rd_q;
    if (push) begin
      desc_q[dwr_idx] <= '{addr: base, size: bus.wr_size, qid: bus.wr_qid, complete: bus.wr_eop};
    end else if (merge) begin
      desc_q[tail_idx].size     <= merge_sum[AW-1:0];
      desc_q[tail_idx].complete <= bus.wr_eop;
    end else if (cont && bus.wr_eop) begin
      desc_q[tail_idx].complete <= 1'b1;
    end
  end

  assign bus.wr_ready      = wr_ready_q;
  assign bus.occupancy     = occupancy_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.dma_req_valid = dma_valid;
  assign bus.dma_req_addr  = desc_q[drd_idx].addr;
  assign bus.dma_req_size  = desc_q[drd_idx].size;
  assign bus.dma_req_qid   = desc_q[drd_idx].qid;
endmodule

// File: tb/tb_mq_ring_buffer.sv
// Directed bench for mq_ring_buffer: a default instance and a MAX_MERGE=8
// instance share one stimulus stream.
module tb_mq_ring_buffer;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [26:0] q_main[$];
  logic [26:0] q_m8[$];

  mq_ring_buffer_if #(.FLIT_W(512), .QID_W(9), .AW(AW)) bus ();
  mq_ring_buffer_if #(.FLIT_W(512), .QID_W(9), .AW(AW)) bus_m8 ();

  always #5 clk = ~clk;

  mq_ring_buffer u_dut (.clk(clk), .rst(rst), .bus(bus));
  mq_ring_buffer #(.MAX_MERGE(8)) u_dut_m8 (.clk(clk), .rst(rst), .bus(bus_m8));

  assign bus_m8.wr_en         = bus.wr_en;
  assign bus_m8.wr_sop        = bus.wr_sop;
  assign bus_m8.wr_eop        = bus.wr_eop;
  assign bus_m8.wr_data       = bus.wr_data;
  assign bus_m8.wr_qid        = bus.wr_qid;
  assign bus_m8.wr_size       = bus.wr_size;
  assign bus_m8.rd_en         = bus.rd_en;
  assign bus_m8.rd_addr       = bus.rd_addr;
  assign bus_m8.dma_req_ready = bus.dma_req_ready;
  assign bus_m8.rel_valid     = bus.rel_valid;
  assign bus_m8.rel_addr      = bus.rel_addr;

  function automatic logic [511:0] pat(input int tag, input int k);
    return {16{16'(tag), 16'(k)}};
  endfunction

  function automatic logic [26:0] enc(input int addr, input int size, input int qid);
    return {9'(addr), 9'(size), 9'(qid)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_sop = 1'b0; bus.wr_eop = 1'b0; bus.wr_data = '0;
    bus.wr_qid = '0; bus.wr_size = '0; bus.rd_en = 1'b0; bus.rd_addr = '0;
    bus.dma_req_ready = 1'b0; bus.rel_valid = 1'b0; bus.rel_addr = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
    q_main.delete();
    q_m8.delete();
  endtask

  task automatic write_pkt(input int qid, input int size, input int tag);
    for (int k = 0; k < size; k++) begin
      bus.wr_en   = 1'b1;
      bus.wr_sop  = (k == 0);
      bus.wr_eop  = (k == size - 1);
      bus.wr_data = pat(tag, k);
      bus.wr_qid  = 9'(qid);
      bus.wr_size = AW'(size);
      tick();
    end
    bus.wr_en = 1'b0; bus.wr_sop = 1'b0; bus.wr_eop = 1'b0;
  endtask

  task automatic release_to(input int addr);
    bus.rel_valid = 1'b1;
    bus.rel_addr  = AW'(addr);
    tick();
    bus.rel_valid = 1'b0;
  endtask

  // Holds ready high for n cycles and logs every request each instance presents.
  task automatic collect(input int n);
    bus.dma_req_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (bus.dma_req_valid)
        q_main.push_back({bus.dma_req_addr, bus.dma_req_size, bus.dma_req_qid});
      if (bus_m8.dma_req_valid)
        q_m8.push_back({bus_m8.dma_req_addr, bus_m8.dma_req_size, bus_m8.dma_req_qid});
      tick();
    end
    bus.dma_req_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %0b want 0", bus.wr_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", bus.rd_valid); end
    checks++; if (bus.dma_req_valid !== 1'b0) begin errors++; $display("FAIL reset_dma_valid got %0b want 0", bus.dma_req_valid); end
    checks++; if (bus.occupancy !== 10'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
    rst = 1'b0;
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready_rise got %0b want 1", bus.wr_ready); end
  endtask

  task automatic test_merge();
    apply_reset();
    write_pkt(5, 4, 1);
    write_pkt(5, 4, 2);
    write_pkt(5, 4, 3);
    checks++; if ({bus.dma_req_valid, bus.dma_req_addr, bus.dma_req_size, bus.dma_req_qid} !== {1'b1, enc(0, 4, 5)}) begin
      errors++; $display("FAIL merge_head got v%0b a%0d s%0d q%0d want v1 a0 s4 q5",
        bus.dma_req_valid, bus.dma_req_addr, bus.dma_req_size, bus.dma_req_qid); end
    tick();
    tick();
    checks++; if ({bus.dma_req_addr, bus.dma_req_size} !== {9'd0, 9'd4}) begin
      errors++; $display("FAIL merge_hold got a%0d s%0d want a0 s4", bus.dma_req_addr, bus.dma_req_size); end
    checks++; if (bus.occupancy !== 10'd12) begin errors++; $display("FAIL merge_occupancy got %0d want 12", bus.occupancy); end
    collect(6);
    checks++; if (q_main.size() !== 2) begin errors++; $display("FAIL merge_count got %0d want 2", q_main.size()); end
    checks++; if (q_main[0] !== enc(0, 4, 5)) begin errors++; $display("FAIL merge_req0 got %h want %h", q_main[0], enc(0, 4, 5)); end
    checks++; if (q_main[1] !== enc(4, 8, 5)) begin errors++; $display("FAIL merge_req1 got %h want %h", q_main[1], enc(4, 8, 5)); end
    checks++; if (bus.dma_req_valid !== 1'b0) begin errors++; $display("FAIL merge_drained got %0b want 0", bus.dma_req_valid); end
  endtask

  task automatic test_alt_qid();
    apply_reset();
    for (int i = 0; i < 4; i++) write_pkt((i % 2) + 1, 2, i + 1);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(3);
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL read_early got %0b want 0", bus.rd_valid); end
    tick();
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL read_valid got %0b want 1", bus.rd_valid); end
    checks++; if (bus.rd_data !== pat(2, 1)) begin errors++; $display("FAIL read_data got %h want %h", bus.rd_data[31:0], pat(2, 1) & 512'hFFFFFFFF); end
    collect(8);
    checks++; if (q_main.size() !== 4) begin errors++; $display("FAIL altq_count got %0d want 4", q_main.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (q_main[i] !== enc(2 * i, 2, (i % 2) + 1)) begin
        errors++; $display("FAIL altq_req%0d got %h want %h", i, q_main[i], enc(2 * i, 2, (i % 2) + 1)); end
    end
  endtask

  task automatic test_wrap();
    int t;
    apply_reset();
    t = 0;
    for (int i = 0; i < 21; i++) begin
      write_pkt(7, (i < 20) ? 24 : 20, i);
      collect(3);
      t += (i < 20) ? 24 : 20;
      release_to(t);
    end
    tick();
    checks++; if (q_main.size() !== 21) begin errors++; $display("FAIL wrap_fill_count got %0d want 21", q_main.size()); end
    checks++; if (bus.occupancy !== 10'd0) begin errors++; $display("FAIL wrap_pre_occupancy got %0d want 0", bus.occupancy); end
    write_pkt(3, 24, 99);
    tick();
    checks++; if ({bus.dma_req_valid, bus.dma_req_addr, bus.dma_req_size, bus.dma_req_qid} !== {1'b1, enc(0, 24, 3)}) begin
      errors++; $display("FAIL wrap_req got v%0b a%0d s%0d q%0d want v1 a0 s24 q3",
        bus.dma_req_valid, bus.dma_req_addr, bus.dma_req_size, bus.dma_req_qid); end
    checks++; if (bus.occupancy !== 10'd36) begin errors++; $display("FAIL wrap_occupancy got %0d want 36", bus.occupancy); end
    collect(3);
    release_to(24);
    tick();
    checks++; if (bus.occupancy !== 10'd0) begin errors++; $display("FAIL wrap_release_occupancy got %0d want 0", bus.occupancy); end
    write_pkt(3, 1, 100);
    checks++; if (bus.dma_req_addr !== 9'd24) begin errors++; $display("FAIL wrap_next_addr got %0d want 24", bus.dma_req_addr); end
  endtask

  task automatic test_merge_limit();
    apply_reset();
    for (int i = 0; i < 4; i++) write_pkt(5, 4, i);
    collect(10);
    checks++; if (q_m8.size() !== 3) begin errors++; $display("FAIL limit_count got %0d want 3", q_m8.size()); end
    checks++; if (q_m8[0] !== enc(0, 4, 5)) begin errors++; $display("FAIL limit_req0 got %h want %h", q_m8[0], enc(0, 4, 5)); end
    checks++; if (q_m8[1] !== enc(4, 8, 5)) begin errors++; $display("FAIL limit_req1 got %h want %h", q_m8[1], enc(4, 8, 5)); end
    checks++; if (q_m8[2] !== enc(12, 4, 5)) begin errors++; $display("FAIL limit_req2 got %h want %h", q_m8[2], enc(12, 4, 5)); end
    checks++; if (q_main.size() !== 2 || q_main[1] !== enc(4, 12, 5)) begin
      errors++; $display("FAIL limit_wide got n%0d %h want n2 %h", q_main.size(), q_main[1], enc(4, 12, 5)); end
  endtask

  task automatic test_fill();
    apply_reset();
    bus.dma_req_ready = 1'b1;
    for (int i = 0; i < 19; i++) write_pkt(4, 24, i);
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_456 got %0b want 1", bus.wr_ready); end
    write_pkt(4, 24, 19);
    tick();
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_480 got %0b want 0", bus.wr_ready); end
    release_to(480);
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL fill_release got %0b want 1", bus.wr_ready); end
    bus.dma_req_ready = 1'b0;
    for (int i = 0; i < 14; i++) write_pkt((i % 2) + 1, 1, i);
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL fill_desc14 got %0b want 1", bus.wr_ready); end
    write_pkt(1, 1, 14);
    tick();
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL fill_desc15 got %0b want 0", bus.wr_ready); end
    q_main.delete();
    collect(20);
    checks++; if (q_main.size() !== 15) begin errors++; $display("FAIL fill_drain got %0d want 15", q_main.size()); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    write_pkt(1, 1, 1);
    write_pkt(2, 1, 2);
    checks++; if (bus.dma_req_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got %0b want 1", bus.dma_req_valid); end
    bus.wr_en = 1'b1; bus.wr_sop = 1'b1; bus.wr_eop = 1'b0; bus.wr_qid = 9'd3;
    bus.wr_size = AW'(4); bus.wr_data = pat(40, 0);
    tick();
    bus.wr_sop = 1'b0; bus.wr_data = pat(40, 1); bus.rd_en = 1'b1; bus.rd_addr = '0;
    tick();
    bus.rd_en = 1'b0; bus.wr_data = pat(40, 2); rst = 1'b1;
    tick();
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL mid_wr_ready got %0b want 0", bus.wr_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid got %0b want 0", bus.rd_valid); end
    checks++; if (bus.dma_req_valid !== 1'b0) begin errors++; $display("FAIL mid_dma_valid got %0b want 0", bus.dma_req_valid); end
    checks++; if (bus.occupancy !== 10'd0) begin errors++; $display("FAIL mid_occupancy got %0d want 0", bus.occupancy); end
    rst = 1'b0; bus.wr_eop = 1'b1; bus.wr_data = pat(40, 3);
    tick();
    bus.wr_en = 1'b0; bus.wr_eop = 1'b0;
    tick();
    checks++; if (bus.dma_req_valid !== 1'b0 || bus.occupancy !== 10'd0) begin
      errors++; $display("FAIL mid_stray got v%0b occ%0d want v0 occ0", bus.dma_req_valid, bus.occupancy); end
    write_pkt(6, 3, 50);
    checks++; if ({bus.dma_req_valid, bus.dma_req_addr, bus.dma_req_size, bus.dma_req_qid} !== {1'b1, enc(0, 3, 6)}) begin
      errors++; $display("FAIL mid_clean got v%0b a%0d s%0d q%0d want v1 a0 s3 q6",
        bus.dma_req_valid, bus.dma_req_addr, bus.dma_req_size, bus.dma_req_qid); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_merge();
    test_alt_qid();
    test_wrap();
    test_merge_limit();
    test_fill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mq_ring_buffer.md
# mq_ring_buffer

Parametrised packet ring buffer with internal write-address allocation, per-queue DMA descriptor coalescing and a valid/ready DMA request interface. It sits between the packet classifier and the PCIe DMA engine. Each packet is stored contiguously in a flit buffer, and one DMA request is emitted per run of same-queue packets. Consumed space is returned by an explicit release.

## Interface
- DEPTH, 512: flit slots in the data buffer (power of two).
- FLIT_W, 512: payload bits per flit.
- QID_W, 9: queue id width.
- MAX_PKT, 24: maximum packet length in flits.
- DESC_DEPTH, 16: descriptor FIFO entries (power of two).
- MAX_MERGE, 64: maximum flits in one coalesced descriptor.
- MERGE_EN, 1: 0 disables coalescing.
- AW: localparam, $clog2(DEPTH).
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  flit valid.
- wr_sop / wr_eop  in  1  start / end of packet.
- wr_data  in  FLIT_W  flit payload.
- wr_qid  in  QID_W  queue id; sampled on sop.
- wr_size  in  AW  packet length in flits, 1..MAX_PKT; sampled on sop.
- wr_ready  out  1  new sop may be presented.
- rd_en  in  1  read strobe.
- rd_addr  in  AW  read address.
- rd_valid  out  1  read data valid.
- rd_data  out  FLIT_W  read data.
- dma_req_valid / dma_req_ready  out/in  1  DMA request handshake.
- dma_req_addr  out  AW  first slot of the request.
- dma_req_size  out  AW  length of the request in flits.
- dma_req_qid  out  QID_W  queue id of the request.
- rel_valid  in  1  consumer releases space.
- rel_addr  in  AW  new head (first still-occupied slot).
- occupancy  out  AW+1  occupied slots, including wrap padding.

## Operation
- Pointers: head, tail (AW bits). occupied = (tail − head) mod DEPTH. free = DEPTH − 1 − occupied. One slot is always left empty.
- Sop accepted (wr_en & wr_sop):
  - If tail + wr_size > DEPTH, base = 0 and slots [tail, DEPTH) become padding. Otherwise base = tail.
  - tail ← (base + wr_size) mod DEPTH.
  - Flit k of the packet is written to base + k. The writer never stalls mid-packet.
- Descriptor FIFO entry: {addr, size, qid, complete}.
- Descriptor on sop: the packet merges into the tail entry only if all of these hold:
  - MERGE_EN = 1;
  - count ≥ 2, so the tail entry is not the head entry;
  - qid matches the tail entry;
  - base = tail entry addr + size, so there is no wrap;
  - merged size ≤ MAX_MERGE.
  - On merge: the tail entry's size += wr_size and complete ← 0.
  - Otherwise a new entry {base, wr_size, wr_qid, 0} is pushed.
- On eop, the tail entry's complete ← 1.
- DMA issue: dma_req_valid = count > 0 & head entry complete. Address, size and qid come from the head entry. The entry is popped on valid & ready.
  - Fields are stable while valid is high and ready is low.
- Release: rel_valid sets head ← rel_addr. The consumer releases in order; padding is freed when head passes it.
- wr_ready (registered) = free ≥ 2·MAX_PKT & count ≤ DESC_DEPTH − 2. This covers worst-case padding plus one new entry. A sop presented while wr_ready is low is a protocol violation and is not checked.
- Simultaneous push/pop or merge/pop in one cycle: count updates by the net change. A merge never targets the entry being popped, because of the count ≥ 2 rule.
- Simultaneous sop and release: both take effect. free is evaluated from pre-cycle pointers.

## Timing
- Reset values: head = tail = 0, count = 0, wr_ready = 0, rd_valid = 0, dma_req_valid = 0, occupancy = 0. wr_ready rises on the first cycle after reset is deasserted.
- Reset mid-packet discards all state. Flits of a partially written packet are ignored until the next sop.
- Read latency is 2 cycles: rd_en in cycle n gives rd_valid/rd_data in cycle n+2, fully pipelined. A read of an address written in the same cycle returns old data.
- Request latency: the eop written in cycle n gives dma_req_valid in cycle n+1 (registered complete flag). A single-flit packet (sop & eop) gives a request in cycle n+1.
- occupancy and wr_ready reflect pointer updates one cycle later.
- dma_req_valid is independent of dma_req_ready; there is no combinational path from ready to valid.

## Test plan
- Reset, then three 4-flit packets on qid 5 written back-to-back with dma_req_ready = 0:
  - entry 0 = {addr 0, size 4};
  - entry 1 = {addr 4, size 8} (2nd and 3rd packets merged);
  - after ready rises, exactly 2 requests are issued.
- Alternating qids 1 and 2, four 2-flit packets -> 4 requests at addrs 0, 2, 4, 6 with no merge; rd of addr 3 returns 2nd packet flit 1 two cycles after rd_en.
- tail = 500, 24-flit packet -> base 0, dma_req_addr 0, occupancy = 36. Release rel_addr = 24 -> occupancy 0 (tail 24).
- MERGE_EN = 1, MAX_MERGE = 8, three 4-flit packets on the same qid behind a pending head entry -> sizes 4, 8, 4.
- Fill until free < 48 -> wr_ready drops within 1 cycle; release restores it within 1 cycle. 15 pending descriptors -> wr_ready low.
- Assert rst mid-packet with 2 pending requests -> all outputs at reset values next cycle; a clean following packet starts at addr 0.
